// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter control sequencer.
// Chooses each cycle between holding, PC+1, PC+2 or loading a branch target,
// squashes the pipeline slots behind an accepted branch, and counts taken
// branches (saturating). Control outputs are combinational from the current
// state, the squash counter and the inputs; branch_count and squashing come
// straight from registers.

module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_valid,
    input  logic        ins_two_word,
    input  logic        bb,
    input  logic        ub_taken,
    input  logic        cb_taken,
    output logic        ipc,
    output logic        dipc,
    output logic        lpc2,
    output logic        lpc3,
    output logic        efl,
    output logic        flush1,
    output logic        flush2,
    output logic        squashing,
    output logic [15:0] branch_count
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        boot_armed_q;       // set by the first edge after reset release
    logic [1:0]  squash_cnt_q, squash_cnt_d;
    logic [15:0] branch_count_q, branch_count_d;
    logic        branch_accept_s;

    // Decode control outputs and next state from state, squash counter and inputs.
    always_comb begin
        ipc             = 1'b0;
        dipc            = 1'b0;
        lpc2            = 1'b0;
        lpc3            = 1'b0;
        efl             = 1'b0;
        flush1          = 1'b0;
        flush2          = 1'b0;
        branch_accept_s = 1'b0;
        state_d         = state_q;
        squash_cnt_d    = squash_cnt_q;

        case (state_q)
            S_BOOT: begin
                // The edge that follows reset release only opens the BOOT cycle;
                // the edge after that moves to RUN.
                squash_cnt_d = 2'd0;
                if (boot_armed_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_BOOT;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
                if ((squash_cnt_q == 2'd0) && cb_taken) begin
                    ipc             = 1'b1;
                    dipc            = 1'b1;
                    lpc3            = 1'b1;
                    efl             = 1'b1;
                    flush1          = 1'b1;
                    flush2          = 1'b1;
                    branch_accept_s = 1'b1;
                    squash_cnt_d    = 2'd2;
                end else if ((squash_cnt_q == 2'd0) && ub_taken) begin
                    ipc             = 1'b1;
                    dipc            = 1'b1;
                    lpc2            = 1'b1;
                    flush1          = 1'b1;
                    branch_accept_s = 1'b1;
                    squash_cnt_d    = 2'd1;
                end else begin
                    // Branches are ignored while squashing; the counter drains
                    // one per cycle regardless of stalls.
                    if (squash_cnt_q != 2'd0) begin
                        squash_cnt_d = squash_cnt_q - 2'd1;
                    end else begin
                        squash_cnt_d = 2'd0;
                    end
                    if (bb) begin
                        ipc  = 1'b0;
                        dipc = 1'b0;
                    end else if (ins_valid && ins_two_word) begin
                        dipc = 1'b1;
                    end else if (ins_valid) begin
                        ipc = 1'b1;
                    end else begin
                        ipc  = 1'b0;
                        dipc = 1'b0;
                    end
                end
            end
            default: begin
                state_d      = S_BOOT;
                squash_cnt_d = 2'd0;
            end
        endcase

        if (branch_accept_s && (branch_count_q != 16'hFFFF)) begin
            branch_count_d = branch_count_q + 16'd1;
        end else begin
            branch_count_d = branch_count_q;
        end
    end

    // Sequencer state, squash counter and saturating branch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_BOOT;
            boot_armed_q   <= 1'b0;
            squash_cnt_q   <= 2'd0;
            branch_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            boot_armed_q   <= 1'b1;
            squash_cnt_q   <= squash_cnt_d;
            branch_count_q <= branch_count_d;
        end
    end

    assign squashing    = (squash_cnt_q != 2'd0);
    assign branch_count = branch_count_q;

endmodule
